// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arb shifter arbiter.
package shift_arb_pkg;

  // Operand/result width is fixed by the shared shifter datapath.
  localparam int SRC_W = 16;
  localparam int AMT_W = 4;

  // Sequencer states: sample requests, drive the shifter, then present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Requester identifier: 0 = requester 0, 1 = requester 1.
  typedef logic req_id_t;

  // Operands captured from the winning requester.
  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [AMT_W-1:0] amt;
    logic             ars;
  } operand_t;

  // Round-robin choice: a lone requester wins; on a tie the one not granted last time wins.
  function automatic req_id_t pick_owner(input logic req0, input logic req1, input req_id_t last);
    req_id_t winner;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    return winner;
  endfunction

endpackage

// File: rtl/shift_arb_shifter.sv
// Combinational 16-bit right shifter with logical/arithmetic fill.
// Built as a 4-stage logarithmic barrel; each stage shifts by a power of two.
module shifter
  import shift_arb_pkg::*;
(
  input  logic [SRC_W-1:0] src,
  input  logic             ars,
  input  logic [AMT_W-1:0] amt,
  output logic [SRC_W-1:0] res
);

  logic             fill;
  logic [SRC_W-1:0] stage1;
  logic [SRC_W-1:0] stage2;
  logic [SRC_W-1:0] stage4;

  // Barrel stages by 1, 2, 4 and 8; fill is the sign bit only for arithmetic shifts.
  always_comb begin
    fill   = ars & src[SRC_W-1];
    stage1 = amt[0] ? {fill, src[SRC_W-1:1]}         : src;
    stage2 = amt[1] ? {{2{fill}}, stage1[SRC_W-1:2]} : stage1;
    stage4 = amt[2] ? {{4{fill}}, stage2[SRC_W-1:4]} : stage2;
    res    = amt[3] ? {{8{fill}}, stage4[SRC_W-1:8]} : stage4;
  end

endmodule

// File: rtl/shift_arb.sv
// Round-robin arbiter/sequencer sharing one shifter between two requesters.
//
// Handshake: a requester raises reqN with srcN/amtN/arsN stable and keeps them so
// until doneN pulses for one cycle; res is valid in that same cycle. The requester
// drops reqN on the edge that ends its done cycle; leaving it high is a fresh
// request whose operands are sampled again in the following IDLE cycle.
// Every output, including the debug state, comes straight from a flop.
module shift_arb
  import shift_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [SRC_W-1:0] src0,
  input  logic [SRC_W-1:0] src1,
  input  logic [AMT_W-1:0] amt0,
  input  logic [AMT_W-1:0] amt1,
  input  logic             ars0,
  input  logic             ars1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [SRC_W-1:0] res,
  output state_t           state
);

  operand_t         op;
  req_id_t          owner;
  req_id_t          last;
  req_id_t          winner;
  operand_t         winner_op;
  logic [SRC_W-1:0] shift_res;

  // Choose the next owner and mux its operands ahead of the capture edge.
  always_comb begin
    winner = pick_owner(req0, req1, last);
    if (winner) begin
      winner_op.src = src1;
      winner_op.amt = amt1;
      winner_op.ars = ars1;
    end else begin
      winner_op.src = src0;
      winner_op.amt = amt0;
      winner_op.ars = ars0;
    end
  end

  // The shifter only ever sees captured operands, so input changes mid-flight are ignored.
  shifter u_shifter (
    .src (op.src),
    .ars (op.ars),
    .amt (op.amt),
    .res (shift_res)
  );

  // Sequencer FSM with registered grant, done and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      res   <= '0;
      op    <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 || req1) begin
            op    <= winner_op;
            owner <= winner;
            last  <= winner;
            gnt0  <= ~winner;
            gnt1  <= winner;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res   <= shift_res;
          done0 <= ~owner;
          done1 <= owner;
          state <= RESP;
        end
        RESP: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Grants and done pulses belong to exactly one requester at a time.
  assert property (@(posedge clk) !(gnt0 && gnt1));
  assert property (@(posedge clk) !(done0 && done1));
  // A done pulse is only ever issued to the current owner.
  assert property (@(posedge clk) done0 |-> gnt0);
  assert property (@(posedge clk) done1 |-> gnt1);

endmodule
